cpu_prog_sequencer: RTL
=======================

// Module: cpu_prog_sequencer
// PURPOSE
//   Synthesisable instruction sequencer that replaces per-step bench fetching for cpu_top.
//   - Holds a parametrised program memory and a program counter.
//   - Drives cpu_top.instruction and times each instruction over the CPU's fixed execute window.
//   - Supports continuous run, single-step, one PC breakpoint, end-of-program halt and restart.
// PARAMETERS
//   INSTR_W     11   instruction width (matches cpu_top.instruction)
//   DEPTH       256  program memory slots
//   ADDR_W      8    PC / memory address width; DEPTH <= 2**ADDR_W
//   EXEC_CYC    3    clocks instruction is held valid per instruction (CPU fetch->store window)
// PORTS
//   clk          in   1        system clock, rising edge
//   reset_n      in   1        asynchronous active-low reset
//   load_en      in   1        program write strobe (honoured only when busy=0)
//   load_addr    in   ADDR_W   program write address
//   load_data    in   INSTR_W  program write data
//   prog_len     in   ADDR_W+1 number of valid instructions (0..DEPTH)
//   run          in   1        level: execute continuously while high
//   step         in   1        one-clock pulse: execute exactly one instruction
//   restart      in   1        one-clock pulse: PC<=0, clear halted/bp_hit (ignored when busy=1)
//   bp_en        in   1        breakpoint enable
//   bp_addr      in   ADDR_W   breakpoint PC
//   instruction  out  INSTR_W  to cpu_top.instruction; 0 outside EXEC
//   instr_valid  out  1        high during the EXEC_CYC clocks of an instruction
//   pc           out  ADDR_W   address of current / next instruction
//   retire       out  1        one-clock pulse when an instruction completes
//   busy         out  1        high in FETCH, EXEC, RETIRE
//   bp_hit       out  1        sticky: run stopped at breakpoint
//   halted       out  1        sticky: PC reached prog_len
// BEHAVIOUR
//   Reset (async, any state): state=IDLE, pc=0, instruction=0; all flags/pulses 0; memory not cleared.
//   Memory: synchronous write when load_en & !busy; synchronous read with 1-clock latency.
//   FSM IDLE -> FETCH -> EXEC -> RETIRE -> (FETCH | IDLE | HALT)
//     IDLE:   halted=0 and pc<prog_len, plus either
//             - step=1 -> FETCH (breakpoint ignored for a step), or
//             - run=1 and !(bp_en & pc==bp_addr & !resume) -> FETCH.
//             run blocked by breakpoint -> bp_hit<=1, stay IDLE.
//             resume: internal flag, set by step or restart, cleared on next FETCH;
//             re-asserting run after a step therefore passes the same bp_addr once.
//             pc>=prog_len on run/step -> HALT.
//     FETCH:  1 clock; memory read at pc.
//     EXEC:   instruction<=mem[pc], instr_valid=1 for exactly EXEC_CYC clocks; instruction held stable.
//     RETIRE: 1 clock; retire=1, instruction=0, pc<=pc+1 (wraps to 0 at 2**ADDR_W).
//             pc+1 (ADDR_W+1-bit compare) == prog_len -> HALT;
//             else run=1 and step not in flight and no bp at pc+1 -> FETCH;
//             else IDLE (bp match in run sets bp_hit).
//     HALT:   halted=1; only restart or reset leaves (restart -> IDLE, pc=0).
//   Latency: step pulse to first instr_valid = 2 clocks; per instruction = EXEC_CYC+2 clocks.
//   run deassert mid-instruction: instruction completes and retires, then IDLE.
//   step during busy: ignored. step and run together in IDLE: treated as run.
//   prog_len=0: any run/step -> HALT immediately, no retire.
//   prog_len=DEPTH=2**ADDR_W: last retire wraps pc to 0 and halts (compare uses ADDR_W+1 bits).
//   bp_hit cleared on next FETCH; halted cleared only by restart/reset.
//   load_en while busy: write dropped, no side effects.
// TESTING
//   Load 4 instrs, prog_len=4, run=1 -> 4 retire pulses 5 clocks apart, pc 0..3, then halted=1, pc=4.
//   step pulse x2, run=0 -> exactly 2 retires, pc=2, busy=0, instr_valid high 3 clocks each.
//   bp_en=1, bp_addr=2, run=1 -> retires pc0,pc1, then bp_hit=1, pc=2; step -> pc=3; run -> continues to halt.
//   reset_n low mid-EXEC -> instruction=0, instr_valid=0, pc=0 same cycle; memory contents retained.
//   prog_len=0, run=1 -> halted=1, no retire; restart -> halted=0, pc=0.
//   load_en during EXEC at current pc -> memory unchanged, running instruction unaffected.

Source files
------------

// File: rtl/cpu_prog_sequencer_if.sv
// Interface bundling the program-load, control and instruction-issue
// signals exchanged between cpu_prog_sequencer and whatever drives it.
interface cpu_prog_sequencer_if #(
    parameter int INSTR_W = 11,
    parameter int ADDR_W  = 8
);
    logic               load_en;
    logic [ADDR_W-1:0]  load_addr;
    logic [INSTR_W-1:0] load_data;
    logic [ADDR_W:0]    prog_len;
    logic               run;
    logic               step;
    logic               restart;
    logic               bp_en;
    logic [ADDR_W-1:0]  bp_addr;
    logic [INSTR_W-1:0] instruction;
    logic               instr_valid;
    logic [ADDR_W-1:0]  pc;
    logic               retire;
    logic               busy;
    logic               bp_hit;
    logic               halted;

    // Controller side: loads the program and steers execution
    modport master (
        output load_en, load_addr, load_data, prog_len,
        output run, step, restart, bp_en, bp_addr,
        input  instruction, instr_valid, pc, retire, busy, bp_hit, halted
    );

    // Sequencer side
    modport slave (
        input  load_en, load_addr, load_data, prog_len,
        input  run, step, restart, bp_en, bp_addr,
        output instruction, instr_valid, pc, retire, busy, bp_hit, halted
    );
endinterface

// File: rtl/cpu_prog_sequencer.sv
// Instruction sequencer for cpu_top: program memory, program counter and a
// FETCH/EXEC/RETIRE pipeline that holds each instruction for EXEC_CYC clocks.
// Supports continuous run, single-step, one PC breakpoint, end-of-program
// halt and restart.
module cpu_prog_sequencer #(
    parameter int INSTR_W  = 11,
    parameter int DEPTH    = 256,
    parameter int ADDR_W   = 8,
    parameter int EXEC_CYC = 3
) (
    input  logic                 clk,
    input  logic                 reset_n,
    cpu_prog_sequencer_if.slave  sq
);
    localparam int               CNT_W    = (EXEC_CYC > 1) ? $clog2(EXEC_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(EXEC_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_RETIRE,
        S_HALT
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [INSTR_W-1:0] r_mem [DEPTH];
    logic [INSTR_W-1:0] r_rd_data;
    logic [ADDR_W-1:0]  r_pc;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_bp_hit;
    logic               r_halted;
    logic               r_resume;
    logic               r_step_flight;

    logic               w_busy;
    logic [ADDR_W:0]    w_pc_ext;
    logic [ADDR_W:0]    w_pc_inc;
    logic               w_bp_here;
    logic               w_bp_next;
    logic               w_launch_run;
    logic               w_launch_step;
    logic               w_set_bp;
    logic               w_restart;

    // The end-of-program compare is one bit wider than the PC so that a
    // full-depth program (prog_len == 2**ADDR_W) is detected on the wrap.
    assign w_pc_ext  = {1'b0, r_pc};
    assign w_pc_inc  = w_pc_ext + {{ADDR_W{1'b0}}, 1'b1};
    assign w_bp_here = sq.bp_en && (r_pc == sq.bp_addr);
    assign w_bp_next = sq.bp_en && (w_pc_inc[ADDR_W-1:0] == sq.bp_addr);
    assign w_busy    = (r_state == S_FETCH) || (r_state == S_EXEC) || (r_state == S_RETIRE);

    // Next-state decode and the one-cycle control strobes that go with it
    always_comb begin
        w_state_nxt   = r_state;
        w_launch_run  = 1'b0;
        w_launch_step = 1'b0;
        w_set_bp      = 1'b0;
        w_restart     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (sq.restart) begin
                    w_restart = 1'b1;
                end else if (sq.run || sq.step) begin
                    if (w_pc_ext >= sq.prog_len) begin
                        w_state_nxt = S_HALT;
                    end else if (sq.run) begin
                        // run wins over a simultaneous step; resume lets run
                        // pass a breakpoint that a step or restart left us on
                        if (w_bp_here && !r_resume) begin
                            w_set_bp = 1'b1;
                        end else begin
                            w_state_nxt  = S_FETCH;
                            w_launch_run = 1'b1;
                        end
                    end else begin
                        w_state_nxt   = S_FETCH;
                        w_launch_step = 1'b1;
                    end
                end
            end
            S_FETCH: begin
                w_state_nxt = S_EXEC;
            end
            S_EXEC: begin
                if (r_cnt == CNT_LAST) begin
                    w_state_nxt = S_RETIRE;
                end
            end
            S_RETIRE: begin
                if (w_pc_inc == sq.prog_len) begin
                    w_state_nxt = S_HALT;
                end else if (sq.run && !r_step_flight && !w_bp_next) begin
                    w_state_nxt  = S_FETCH;
                    w_launch_run = 1'b1;
                end else begin
                    w_state_nxt = S_IDLE;
                    w_set_bp    = sq.run && !r_step_flight && w_bp_next;
                end
            end
            S_HALT: begin
                if (sq.restart) begin
                    w_state_nxt = S_IDLE;
                    w_restart   = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Program counter, execute-window counter and sticky status flags
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pc          <= '0;
            r_cnt         <= '0;
            r_bp_hit      <= 1'b0;
            r_halted      <= 1'b0;
            r_resume      <= 1'b0;
            r_step_flight <= 1'b0;
        end else begin
            r_cnt <= (r_state == S_EXEC) ? r_cnt + CNT_W'(1) : '0;
            if (w_restart) begin
                r_pc     <= '0;
                r_halted <= 1'b0;
                r_bp_hit <= 1'b0;
                r_resume <= 1'b1;
            end
            if (r_state == S_RETIRE) begin
                r_pc          <= w_pc_inc[ADDR_W-1:0];
                r_step_flight <= 1'b0;
            end
            if (w_launch_step) begin
                r_step_flight <= 1'b1;
                r_resume      <= 1'b1;
                r_bp_hit      <= 1'b0;
            end
            if (w_launch_run) begin
                r_resume <= 1'b0;
                r_bp_hit <= 1'b0;
            end
            if (w_set_bp) begin
                r_bp_hit <= 1'b1;
            end
            if ((w_state_nxt == S_HALT) && (r_state != S_HALT)) begin
                r_halted <= 1'b1;
            end
        end
    end

    // Program memory: writes only while idle, registered read during FETCH
    always_ff @(posedge clk) begin
        if (sq.load_en && !w_busy) begin
            r_mem[sq.load_addr] <= sq.load_data;
        end
        if (r_state == S_FETCH) begin
            r_rd_data <= r_mem[r_pc];
        end
    end

    assign sq.instruction = (r_state == S_EXEC) ? r_rd_data : '0;
    assign sq.instr_valid = (r_state == S_EXEC);
    assign sq.pc          = r_pc;
    assign sq.retire      = (r_state == S_RETIRE);
    assign sq.busy        = w_busy;
    assign sq.bp_hit      = r_bp_hit;
    assign sq.halted      = r_halted;
endmodule
